// File: rtl/chip_link_pkg.sv
// Shared definitions for the inter-chip link transmitter: width helpers,
// derived word/beat geometry and the serializer FSM encoding.
`timescale 1ns/1ps

package chip_link_pkg;

    // Smallest r with 2^r >= value (0 for value <= 1).
    function automatic int log2_ceil(input int value);
        for (int r = 0; r < 31; r++) begin
            if ((1 << r) >= value) begin
                return r;
            end
        end
        return 31;
    endfunction

    // Link word = flit plus the port-select bits placed above it.
    function automatic int calc_dw(input int fw, input int connect);
        return fw + log2_ceil(connect);
    endfunction

    // Number of link beats needed to carry one word.
    function automatic int calc_nbeats(input int dw, input int lw);
        return (dw + lw - 1) / lw;
    endfunction

    // Serializer FSM encoding.
    localparam int STATE_W = 1;
    localparam logic [STATE_W-1:0] ST_IDLE = 1'b0;
    localparam logic [STATE_W-1:0] ST_SEND = 1'b1;

endpackage

// File: rtl/chip_link_fifo.sv
// Synchronous send FIFO for the link transmitter. Head word is visible
// combinationally so the serializer can load it on the same edge it pops.
// A push while holding DEPTH words is accepted only if a pop frees a slot
// in the same cycle; otherwise the word is dropped and drop_o pulses.
`timescale 1ns/1ps

module chip_link_fifo
    import chip_link_pkg::*;
#(
    parameter int W = 60,
    parameter int B = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         rd_i,
    output logic [W-1:0] rd_data_o,
    output logic [B:0]   count_o,
    output logic         full_o,
    output logic         drop_o
);

    localparam int DEPTH = 1 << B;
    localparam logic [B:0] CAP       = (B+1)'(DEPTH);
    localparam logic [B:0] FULL_MARK = (B+1)'(DEPTH - 1);

    logic [W-1:0] mem [DEPTH];
    logic [B-1:0] wr_ptr_q;
    logic [B-1:0] rd_ptr_q;
    logic [B:0]   count_q;

    logic at_cap;
    logic pop_ok;
    logic push_ok;

    assign at_cap  = (count_q == CAP);
    assign pop_ok  = rd_i && (count_q != '0);
    assign push_ok = wr_i && (!at_cap || pop_ok);
    assign drop_o  = wr_i && at_cap && !pop_ok;

    assign rd_data_o = mem[rd_ptr_q];
    assign count_o   = count_q;
    // One slot of slack covers the upstream mux's registered write strobe.
    assign full_o    = (count_q >= FULL_MARK);

    // Storage array, written only on an accepted push (no reset needed).
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/chip_link_tx.sv
// Inter-chip link transmitter: buffers {port_sel, flit} words from the
// chip-side mux and serializes each into NBEATS LSB-first beats of LW bits
// with first/last markers and valid/ready flow control. Consecutive words
// are sent with no idle beat between them.
`timescale 1ns/1ps

module chip_link_tx
    import chip_link_pkg::*;
#(
    parameter int FW      = 59,
    parameter int CONNECT = 2,
    parameter int B       = 4,
    parameter int LW      = 16,
    localparam int DW     = calc_dw(FW, CONNECT),
    localparam int NBEATS = calc_nbeats(DW, LW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          data_out_wr,
    input  logic [DW-1:0] data_out,
    output logic          send_fifo_full,
    output logic          link_valid,
    input  logic          link_ready,
    output logic [LW-1:0] link_data,
    output logic          link_first,
    output logic          link_last,
    output logic          overflow_err
);

    localparam int PW = NBEATS * LW;
    localparam int IW = (NBEATS > 1) ? log2_ceil(NBEATS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBEATS - 1);

    // Send FIFO
    logic [DW-1:0] fifo_head;
    logic [B:0]    fifo_count;
    logic          fifo_drop;
    logic          fifo_empty;
    logic          pop;

    chip_link_fifo #(
        .W (DW),
        .B (B)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_i      (data_out_wr),
        .wr_data_i (data_out),
        .rd_i      (pop),
        .rd_data_o (fifo_head),
        .count_o   (fifo_count),
        .full_o    (send_fifo_full),
        .drop_o    (fifo_drop)
    );

    assign fifo_empty = (fifo_count == '0);

    // Serializer state
    logic [STATE_W-1:0] state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [DW-1:0]      sr_q, sr_d;
    logic               valid_q, first_q, last_q;
    logic [LW-1:0]      data_q, data_d;
    logic               overflow_q;

    // Next state, beat index and FIFO pop decision.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (link_ready) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + IW'(1);
                    end else if (!fifo_empty) begin
                        // Chain straight into the next word: no bubble.
                        pop   = 1'b1;
                        idx_d = '0;
                    end else begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sr_d = pop ? fifo_head : sr_q;

    // Beat slicing of the word about to be presented; pad bits are zero.
    logic [PW-1:0] src_pad;
    logic [LW-1:0] beat_arr [NBEATS];

    assign src_pad = PW'(sr_d);

    for (genvar gi = 0; gi < NBEATS; gi++) begin : g_beat
        assign beat_arr[gi] = src_pad[gi*LW +: LW];
    end

    // Payload for the next cycle; zero while idle keeps the bus quiet.
    always_comb begin
        data_d = '0;
        if (state_d == ST_SEND) begin
            data_d = beat_arr[idx_d];
        end
    end

    // Registered FSM, shift register and link outputs; reset aborts a word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            sr_q    <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
            valid_q <= (state_d == ST_SEND);
            first_q <= (state_d == ST_SEND) && (idx_d == '0);
            last_q  <= (state_d == ST_SEND) && (idx_d == LAST_IDX);
            data_q  <= data_d;
        end
    end

    // Sticky record of any word dropped at the FIFO input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (fifo_drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign link_valid   = valid_q;
    assign link_first   = first_q;
    assign link_last    = last_q;
    assign link_data    = data_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_chip_link_tx.sv
// Directed self-checking bench for chip_link_tx. dut1 uses the default
// geometry (60-bit words); dut2 uses FW=60, CONNECT=4 (62-bit words) to
// check placement of the port-select bits in the final beat.
`timescale 1ns/1ps

module tb_chip_link_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        wr1;
    logic [59:0] dout1;
    logic        full1, valid1, ready1, first1, last1, ovf1;
    logic [15:0] data1;

    logic        wr2;
    logic [61:0] dout2;
    logic        full2, valid2, ready2, first2, last2, ovf2;
    logic [15:0] data2;

    int n_checks = 0;
    int n_fail   = 0;

    chip_link_tx dut1 (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_out_wr    (wr1),
        .data_out       (dout1),
        .send_fifo_full (full1),
        .link_valid     (valid1),
        .link_ready     (ready1),
        .link_data      (data1),
        .link_first     (first1),
        .link_last      (last1),
        .overflow_err   (ovf1)
    );

    chip_link_tx #(
        .FW      (60),
        .CONNECT (4),
        .B       (4),
        .LW      (16)
    ) dut2 (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_out_wr    (wr2),
        .data_out       (dout2),
        .send_fifo_full (full2),
        .link_valid     (valid2),
        .link_ready     (ready2),
        .link_data      (data2),
        .link_first     (first2),
        .link_last      (last2),
        .overflow_err   (ovf2)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [59:0] w);
        wr1   = 1'b1;
        dout1 = w;
        tick();
        wr1   = 1'b0;
    endtask

    task automatic test_reset();
        logic [19:0] obs;
        rst_n = 1'b0;
        wr1 = 1'b0; dout1 = '0; ready1 = 1'b0;
        wr2 = 1'b0; dout2 = '0; ready2 = 1'b0;
        #2;
        obs = {valid1, first1, last1, data1, ovf1};
        n_checks++;
        if (obs !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs_dut1: got %h expected %h", obs, 20'h0);
        end
        obs = {valid2, first2, last2, data2, ovf2};
        n_checks++;
        if (obs !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs_dut2: got %h expected %h", obs, 20'h0);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({full1, valid1, full2, valid2} !== 4'b0000) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %b expected %b", {full1, valid1, full2, valid2}, 4'b0000);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_word();
        logic [15:0] exp_beats [4];
        logic [18:0] obs, exp;
        exp_beats[0] = 16'h5678; exp_beats[1] = 16'h1234;
        exp_beats[2] = 16'hDEF0; exp_beats[3] = 16'h0ABC;
        ready1 = 1'b1;
        push1(60'h0ABC_DEF0_1234_5678);
        n_checks++;
        if (valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latency_early: got valid=%b expected 0", valid1);
        end
        for (int b = 0; b < 4; b++) begin
            tick();
            obs = {valid1, first1, last1, data1};
            exp = {1'b1, (b == 0), (b == 3), exp_beats[b]};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL single_beat%0d: got {v,f,l,d}=%h expected %h", b, obs, exp);
            end
        end
        tick();
        n_checks++;
        if (valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end_idle: got valid=%b expected 0", valid1);
        end
        $display("test_single_word done");
    endtask

    task automatic test_back_pressure();
        logic [15:0] exp_beats [4];
        logic [18:0] obs, exp;
        exp_beats[0] = 16'h5678; exp_beats[1] = 16'h1234;
        exp_beats[2] = 16'hDEF0; exp_beats[3] = 16'h0ABC;
        ready1 = 1'b1;
        push1(60'h0ABC_DEF0_1234_5678);
        for (int b = 0; b < 3; b++) begin
            tick();
            obs = {valid1, first1, last1, data1};
            exp = {1'b1, (b == 0), 1'b0, exp_beats[b]};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL bp_beat%0d: got %h expected %h", b, obs, exp);
            end
        end
        ready1 = 1'b0;
        exp = {1'b1, 1'b0, 1'b0, exp_beats[2]};
        for (int c = 0; c < 5; c++) begin
            tick();
            obs = {valid1, first1, last1, data1};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got %h expected %h", c, obs, exp);
            end
        end
        ready1 = 1'b1;
        tick();
        obs = {valid1, first1, last1, data1};
        exp = {1'b1, 1'b0, 1'b1, exp_beats[3]};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL bp_beat3: got %h expected %h", obs, exp);
        end
        tick();
        n_checks++;
        if (valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_end_idle: got valid=%b expected 0", valid1);
        end
        $display("test_back_pressure done");
    endtask

    task automatic test_back_to_back();
        logic [59:0] words [3];
        logic [15:0] exp_beats [12];
        logic [18:0] obs, exp;
        int n;
        words[0] = 60'h111_2222_3333_4444;
        words[1] = 60'h555_6666_7777_8888;
        words[2] = 60'h999_AAAA_BBBB_CCCC;
        for (int w = 0; w < 3; w++) begin
            for (int b = 0; b < 4; b++) begin
                exp_beats[w*4+b] = words[w][b*16 +: 16];
            end
        end
        ready1 = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (c < 3) begin
                wr1 = 1'b1;
                dout1 = words[c];
            end else begin
                wr1 = 1'b0;
            end
            tick();
            if (n > 0 && n < 12) begin
                n_checks++;
                if (valid1 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_bubble_after_beat%0d: got valid=%b expected 1", n, valid1);
                end
            end
            if (valid1 === 1'b1 && n < 12) begin
                obs = {valid1, first1, last1, data1};
                exp = {1'b1, (n % 4 == 0), (n % 4 == 3), exp_beats[n]};
                n_checks++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_beat%0d: got %h expected %h", n, obs, exp);
                end
                n++;
            end
        end
        n_checks++;
        if (n != 12) begin
            n_fail++;
            $display("FAIL b2b_beat_count: got %0d expected 12", n);
        end
        n_checks++;
        if (valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end_idle: got valid=%b expected 0", valid1);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_full_overflow();
        int words;
        logic [15:0] exp_id;
        ready1 = 1'b0;
        // Primer word parks in the serializer, stalled by link_ready = 0.
        push1({44'h0, 16'd100});
        tick();
        n_checks++;
        if ({valid1, data1} !== {1'b1, 16'd100}) begin
            n_fail++;
            $display("FAIL ovf_primer: got %h expected %h", {valid1, data1}, {1'b1, 16'd100});
        end
        for (int i = 1; i <= 17; i++) begin
            wr1 = 1'b1;
            dout1 = {44'h0, 16'(i)};
            tick();
            n_checks++;
            if (full1 !== (i >= 15)) begin
                n_fail++;
                $display("FAIL ovf_full_after_write%0d: got %b expected %b", i, full1, (i >= 15));
            end
            if (i >= 16) begin
                n_checks++;
                if (ovf1 !== (i == 17)) begin
                    n_fail++;
                    $display("FAIL ovf_flag_after_write%0d: got %b expected %b", i, ovf1, (i == 17));
                end
            end
        end
        wr1 = 1'b0;
        ready1 = 1'b1;
        words = 0;
        for (int c = 0; c < 200 && words < 17; c++) begin
            if (valid1 === 1'b1 && first1 === 1'b1) begin
                exp_id = (words == 0) ? 16'd100 : 16'(words);
                n_checks++;
                if (data1 !== exp_id) begin
                    n_fail++;
                    $display("FAIL ovf_drain_word%0d: got %h expected %h", words, data1, exp_id);
                end
            end
            if (valid1 === 1'b1 && last1 === 1'b1) begin
                words++;
            end
            tick();
        end
        n_checks++;
        if (words != 17) begin
            n_fail++;
            $display("FAIL ovf_drain_count: got %0d expected 17", words);
        end
        n_checks++;
        if ({valid1, full1, ovf1} !== 3'b001) begin
            n_fail++;
            $display("FAIL ovf_after_drain: got {v,full,ovf}=%b expected 001", {valid1, full1, ovf1});
        end
        $display("test_full_overflow done");
    endtask

    task automatic test_reset_mid_word();
        ready1 = 1'b1;
        push1(60'h0ABC_DEF0_1234_5678);
        push1(60'h0FED_CBA9_8765_4321);
        tick();
        n_checks++;
        if ({valid1, data1} !== {1'b1, 16'h1234}) begin
            n_fail++;
            $display("FAIL rst_mid_pre_beat1: got %h expected %h", {valid1, data1}, {1'b1, 16'h1234});
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({valid1, first1, last1, data1, full1, ovf1} !== 21'h0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got %h expected %h", {valid1, first1, last1, data1, full1, ovf1}, 21'h0);
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_checks++;
            if (valid1 !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_quiet%0d: got valid=%b expected 0", c, valid1);
            end
        end
        $display("test_reset_mid_word done");
    endtask

    task automatic test_port_select();
        logic [15:0] exp_beats [4];
        logic [18:0] obs, exp;
        exp_beats[0] = 16'h5678; exp_beats[1] = 16'h1234;
        exp_beats[2] = 16'hDEF0; exp_beats[3] = 16'h3ABC;
        ready2 = 1'b1;
        wr2 = 1'b1;
        dout2 = {2'b11, 60'hABC_DEF0_1234_5678};
        tick();
        wr2 = 1'b0;
        for (int b = 0; b < 4; b++) begin
            tick();
            obs = {valid2, first2, last2, data2};
            exp = {1'b1, (b == 0), (b == 3), exp_beats[b]};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL portsel_beat%0d: got %h expected %h", b, obs, exp);
            end
        end
        n_checks++;
        if (data2[15:12] !== 4'b0011) begin
            n_fail++;
            $display("FAIL portsel_top_bits: got %b expected 0011", data2[15:12]);
        end
        tick();
        n_checks++;
        if (valid2 !== 1'b0) begin
            n_fail++;
            $display("FAIL portsel_end_idle: got valid=%b expected 0", valid2);
        end
        $display("test_port_select done");
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_pressure();
        test_back_to_back();
        test_full_overflow();
        test_reset_mid_word();
        test_port_select();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
